// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle ALU initiator with a 16x4 register file.
// SUB/ADD are executed by the external ALU; ASCEND/DESCEND run as an in-place bubble sort.
module alu_sequencer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_op,
  input  logic [AW-1:0]    instr_a1,
  input  logic [AW-1:0]    instr_a2,
  input  logic [AW-1:0]    instr_dst,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_v1,
  output logic [WIDTH-1:0] alu_v2,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done
);
  localparam logic [2:0] OP_SUB = 3'b001, OP_ADD = 3'b010, OP_ASC = 3'b011, OP_DESC = 3'b100;
  localparam logic [AW-1:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, EXEC, SORT_CMP, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [2:0] op;
  logic [AW-1:0] a1, a2, dst, i, e, i1;
  logic swapped, accept, alu_op, sort_op, swap_now, last, finish;
  logic [WIDTH-1:0] v_i, v_n;
  assign instr_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign accept = instr_valid && instr_ready;
  assign rd_data = mem[rd_addr];
  assign alu_opcode = state == EXEC ? op : 3'b000;
  assign alu_v1 = state == EXEC ? mem[a1] : '0;
  assign alu_v2 = state == EXEC ? mem[a2] : '0;
  always_comb begin
    i1 = i + ONE;
    v_i = mem[i];
    v_n = mem[i1];
    swap_now = op == OP_DESC ? v_i < v_n : v_i > v_n;
    last = i1 >= e;
    // a swap on the final compare of a pass still forces another pass
    finish = !(swapped || swap_now) || (e - ONE) == a1;
    alu_op = instr_op == OP_SUB || instr_op == OP_ADD;
    sort_op = (instr_op == OP_ASC || instr_op == OP_DESC) && instr_a1 < instr_a2;
    state_n = state == IDLE     ? (accept ? (alu_op ? EXEC : sort_op ? SORT_CMP : DONE) : IDLE)
            : state == EXEC     ? DONE
            : state == SORT_CMP ? (last && finish ? DONE : SORT_CMP)
            : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op <= '0;
      a1 <= '0;
      a2 <= '0;
      dst <= '0;
      i <= '0;
      e <= '0;
      swapped <= 1'b0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op <= instr_op;
        a1 <= instr_a1;
        a2 <= instr_a2;
        dst <= instr_dst;
        i <= instr_a1;
        e <= instr_a2;
        swapped <= 1'b0;
      end
      if (state == IDLE && ld_en) mem[ld_addr] <= ld_data;
      if (state == EXEC) mem[dst] <= alu_out;
      if (state == SORT_CMP) begin
        if (swap_now) begin
          mem[i] <= v_n;
          mem[i1] <= v_i;
        end
        if (!last) begin
          i <= i1;
          swapped <= swapped || swap_now;
        end else begin
          i <= a1;
          e <= e - ONE;
          swapped <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and randomized checks against an array-based reference model.
module tb_alu_sequencer;
  logic clk = 0, reset = 1, instr_valid = 0, ld_en = 0;
  logic instr_ready, busy, done;
  logic [2:0] instr_op = 0, alu_opcode;
  logic [3:0] instr_a1 = 0, instr_a2 = 0, instr_dst = 0, ld_addr = 0, ld_data = 0, rd_addr = 0;
  logic [3:0] alu_v1, alu_v2, alu_out, rd_data;
  int total = 0, bad = 0;
  logic [3:0] mdl [16];

  always #5 clk = ~clk;
  assign alu_out = alu_opcode == 3'd1 ? alu_v2 - alu_v1 : alu_opcode == 3'd2 ? alu_v1 + alu_v2 : 4'd0;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_a1(instr_a1), .instr_a2(instr_a2), .instr_dst(instr_dst),
    .alu_opcode(alu_opcode), .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_out(alu_out),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input int d);
    ld_en = 1; ld_addr = 4'(a); ld_data = 4'(d);
    tick;
    ld_en = 0;
    mdl[a] = 4'(d);
  endtask

  task automatic check_mem;
    for (int k = 0; k < 16; k++) begin
      rd_addr = 4'(k);
      #1;
      chk($sformatf("mem%0d", k), rd_data, mdl[k]);
    end
  endtask

  // Bubble sort with early exit; cyc counts one compare per cycle.
  task automatic sort_model(input bit desc, input int lo, input int hi, output int cyc);
    int e = hi;
    bit go = 1, sw;
    logic [3:0] t;
    cyc = 0;
    while (go) begin
      sw = 0;
      for (int k = lo; k < e; k++) begin
        cyc++;
        if (desc ? mdl[k] < mdl[k+1] : mdl[k] > mdl[k+1]) begin
          t = mdl[k]; mdl[k] = mdl[k+1]; mdl[k+1] = t; sw = 1;
        end
      end
      go = sw && (e - 1 != lo);
      e--;
    end
  endtask

  // mode 0: plain; 1: load at the accept edge; 2: load attempt while busy
  task automatic run(input int op, input int a1, input int a2, input int dst,
                     input int mode = 0, input int la = 0, input int lv = 0);
    int n = 0, exp_n;
    logic [3:0] x, y;
    instr_op = 3'(op); instr_a1 = 4'(a1); instr_a2 = 4'(a2); instr_dst = 4'(dst);
    instr_valid = 1;
    if (mode == 1) begin
      ld_en = 1; ld_addr = 4'(la); ld_data = 4'(lv); mdl[la] = 4'(lv);
    end
    chk("ready", instr_ready, 1);
    tick;
    instr_valid = 0; ld_en = 0;
    if (op == 1 || op == 2) begin
      x = mdl[a1]; y = mdl[a2];
      chk("alu_opc", alu_opcode, op);
      chk("alu_v1", alu_v1, x);
      chk("alu_v2", alu_v2, y);
      mdl[dst] = op == 1 ? 4'(y - x) : 4'(x + y);
      exp_n = 1;
    end else if ((op == 3 || op == 4) && a1 < a2) sort_model(op == 4, a1, a2, exp_n);
    else exp_n = 0;
    while (!done && n < 300) begin
      if (mode == 2 && n == 1) begin
        ld_en = 1; ld_addr = 4'(la); ld_data = 4'(lv);
      end
      chk("busy_run", busy, 1);
      tick;
      ld_en = 0;
      n++;
    end
    chk($sformatf("latency_op%0d", op), n, exp_n);
    chk("busy_done", busy, 1);
    chk("ready_done", instr_ready, 0);
    tick;
    chk("done_clear", done, 0);
    chk("idle", busy, 0);
    check_mem;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) mdl[k] = 0;
    #12;
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_opc", alu_opcode, 0);
    chk("rst_v1", alu_v1, 0);
    chk("rst_v2", alu_v2, 0);
    reset = 0;
    check_mem;
    load(2, 9); load(5, 3);
    run(1, 5, 2, 7);
    chk("sub_result", mdl[7], 6);
    load(0, 12); load(1, 7);
    run(2, 0, 1, 0);
    load(0, 5); load(1, 1); load(2, 4); load(3, 1); load(4, 0); load(5, 9);
    run(3, 0, 5, 0);
    load(0, 5); load(1, 1); load(2, 4); load(3, 1); load(4, 0); load(5, 9);
    run(4, 0, 5, 0, 2, 2, 15);
    load(3, 1); load(4, 2); load(5, 3); load(6, 4);
    run(3, 3, 6, 0);
    run(3, 8, 8, 0);
    run(3, 9, 4, 0);
    run(0, 1, 2, 3);
    run(7, 1, 2, 3);
    run(2, 2, 2, 3, 1, 2, 15);
    chk("ld_accept", mdl[3], 14);
    for (int k = 0; k < 16; k++) load(k, 15 - k);
    instr_op = 3; instr_a1 = 0; instr_a2 = 15; instr_valid = 1;
    tick;
    instr_valid = 0;
    repeat (5) tick;
    #2 reset = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", instr_ready, 1);
    chk("mid_rst_opc", alu_opcode, 0);
    @(posedge clk);
    #1 reset = 0;
    for (int k = 0; k < 16; k++) mdl[k] = 0;
    for (int k = 0; k < 3; k++) begin
      chk("mid_rst_nodone", done, 0);
      tick;
    end
    check_mem;
    load(4, 6); load(9, 11);
    run(2, 4, 9, 9);
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 4)) load($urandom_range(0, 15), $urandom_range(0, 15));
      run($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
